instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of wait cycles for imem_ack before a fault.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; equals pc.
REQ-007 imem_ack  input  1  imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  instruction register (IR).
REQ-010 OpCode  output  6  IR[31:26]; feeds the control decoder.
REQ-011 funct  output  6  IR[5:0]; feeds the control decoder.
REQ-012 instr_valid  output  1  IR holds an instruction awaiting retirement.
REQ-013 instr_ready  input  1  downstream retires the IR this cycle.
REQ-014 jump  input  1  decoder jump for the current IR.
REQ-015 Branch  input  1  decoder branch for the current IR.
REQ-016 zero  input  1  ALU zero flag for the current IR.
REQ-017 pc  output  32  address of the instruction in the IR.
REQ-018 pc_plus4  output  32  pc + 4; used for link and for branch-base calculation.
REQ-019 fault  output  1  sticky fault flag.

Function
REQ-020 SHALL implement FSM states FETCH, HOLD and HALT.
REQ-021 FETCH: imem_req=1, instr_valid=0, wait counter increments each cycle.
REQ-022 FETCH + imem_ack: SHALL load IR from imem_rdata, clear the wait counter and go to HOLD on the next edge; latency from request to instr_valid is ack cycle + 1.
REQ-023 FETCH: the wait counter reaching TIMEOUT without an ack SHALL set fault and go to HALT.
REQ-024 HOLD: imem_req=0, instr_valid=1; IR, pc, OpCode and funct stay stable until retired.
REQ-025 HOLD + instr_ready: SHALL load pc with next_pc and go to FETCH.
REQ-026 next_pc selection:
- jump=1: {pc_plus4[31:28], IR[25:0], 2'b00}.
- else Branch & zero: pc_plus4 + (signext(IR[15:0]) << 2), 32-bit wrap-around.
- else: pc_plus4.
REQ-027 jump=1 and Branch=1 together: jump SHALL take priority.
REQ-028 next_pc[1:0] != 0 on retirement SHALL set fault and go to HALT; pc is not updated.
REQ-029 HALT: imem_req=0, instr_valid=0, all state frozen; the only exit is reset.
REQ-030 imem_ack outside FETCH SHALL be ignored; IR is not modified.
REQ-031 jump, Branch, zero and instr_ready outside HOLD SHALL be ignored.
REQ-032 pc = 32'hFFFF_FFFC SHALL give pc_plus4 = 32'h0000_0000 (wrap-around, no fault).
REQ-033 pc_plus4 SHALL be combinational from pc; OpCode and funct SHALL be combinational from IR.

Reset
REQ-034 rst_n low SHALL immediately, asynchronously, force:
- pc = RESET_PC, IR = 0, wait counter = 0, fault = 0, state = FETCH;
- outputs imem_req = 0 and instr_valid = 0 while rst_n is low.
REQ-035 Reset asserted mid-fetch or in HALT SHALL abandon the transaction; the first request after release is to RESET_PC.
REQ-036 imem_req SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-037 State encodings, RESET_PC default and the instruction field bit positions SHALL live in the shared definitions include used by the control decoder.
REQ-038 The next-PC mux SHALL be one sub-module, npc, purely combinational; FSM and registers SHALL stay in instr_fetch.

Verification
REQ-039 Reset, then imem_ack with 32'h0000_0021 two cycles after the request -> instr_valid high the next cycle, OpCode=0, funct=6'h21, pc=32'h0000_3000.
REQ-040 Retire with jump=1, IR[25:0]=26'h0000C10 -> next imem_addr = 32'h0000_3040.
REQ-041 Retire with Branch=1, zero=1, IR[15:0]=16'hFFFF at pc=32'h0000_3008 -> next imem_addr = 32'h0000_3008; with zero=0 -> 32'h0000_300C.
REQ-042 No imem_ack for TIMEOUT cycles -> fault=1 and imem_req=0 permanently; rst_n pulse clears fault and restarts at 32'h0000_3000.
REQ-043 instr_ready held low for 5 cycles in HOLD, with a spurious imem_ack and changing imem_rdata -> IR and pc unchanged.
REQ-044 rst_n asserted in the cycle imem_ack arrives -> IR = 0 and the next request is to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: FSM encodings, reset vector and IR field positions.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Instruction field bit positions, shared with the control decoder
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/instr_fetch_npc.sv
// Next-PC selection: jump target, taken-branch target, or sequential pc+4.
module instr_fetch_npc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] target,
  input  logic [15:0] imm,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] boff;

  // Jump wins over branch; branch offset is sign-extended word offset, wraps at 32 bits
  always_comb begin
    boff    = {{14{imm[IMM_MSB - IMM_LSB]}}, imm, 2'b00};
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], target[TARGET_MSB - TARGET_LSB:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + boff;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, instruction register, fetch handshake FSM with ack timeout.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        Branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  if_state_t   state;
  logic [31:0] ir;
  logic [CW-1:0] wcnt;
  logic [31:0] next_pc;

  assign instr     = ir;
  assign OpCode    = ir[OPCODE_MSB:OPCODE_LSB];
  assign funct     = ir[FUNCT_MSB:FUNCT_LSB];
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  instr_fetch_npc u_npc (
    .pc_plus4 (pc_plus4),
    .target   (ir[TARGET_MSB:TARGET_LSB]),
    .imm      (ir[IMM_MSB:IMM_LSB]),
    .jump     (jump),
    .branch   (Branch),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  // Fetch FSM with registered request/valid outputs.
  // Out of reset the state is FETCH with imem_req low; the first edge raises the
  // request, so ack is only honoured once the request is actually visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      wcnt        <= '0;
      fault       <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
            wcnt     <= '0;
          end else if (imem_ack) begin
            ir          <= imem_rdata;
            wcnt        <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else if (wcnt == TMAX) begin
            fault    <= 1'b1;
            imem_req <= 1'b0;
            state    <= HALT;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              wcnt     <= '0;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        Branch;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  // second instance with a misaligned reset vector to reach the alignment fault
  logic        rst2_n;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [5:0]  opc2;
  logic [5:0]  fn2;
  logic        valid2;
  logic        ready2;
  logic [31:0] pc2;
  logic [31:0] pcp4_2;
  logic        fault2;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .OpCode(OpCode),
    .funct(funct), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump(jump), .Branch(Branch), .zero(zero), .pc(pc), .pc_plus4(pc_plus4),
    .fault(fault)
  );

  instr_fetch #(.RESET_PC(32'h0000_3002), .TIMEOUT(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .instr(instr2), .OpCode(opc2),
    .funct(fn2), .instr_valid(valid2), .instr_ready(ready2),
    .jump(1'b0), .Branch(1'b0), .zero(1'b0), .pc(pc2), .pc_plus4(pcp4_2),
    .fault(fault2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, optionally idle some cycles, then deliver one word.
  task automatic fetch(input logic [31:0] word, input int unsigned gap);
    int unsigned n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_req: imem_req=%b expected 1", imem_req);
    end
    repeat (gap) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    tests++;
    if (instr_valid !== 1'b1 || instr !== word) begin
      fails++;
      $display("FAIL fetch_load: valid=%b instr=%h expected 1/%h", instr_valid, instr, word);
    end
  endtask

  task automatic retire(input logic j, input logic b, input logic z);
    instr_ready = 1'b1;
    jump        = j;
    Branch      = b;
    zero        = z;
    tick();
    instr_ready = 1'b0;
    jump        = 1'b0;
    Branch      = 1'b0;
    zero        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    jump = 1'b0; Branch = 1'b0; zero = 1'b0;
    ack2 = 1'b0; rdata2 = '0; ready2 = 1'b0;
    repeat (2) tick();
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: req=%b valid=%b fault=%b expected 0/0/0", imem_req, instr_valid, fault);
    end
    tests++;
    if (pc !== 32'h0000_3000 || instr !== 32'h0 || imem_addr !== 32'h0000_3000) begin
      fails++;
      $display("FAIL reset_regs: pc=%h instr=%h addr=%h expected 00003000/0/00003000", pc, instr, imem_addr);
    end
    rst_n = 1'b1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: imem_req=%b expected 0 before first edge", imem_req);
    end
    tick();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h valid=%b expected 1/00003000/0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_fetch_latency();
    repeat (2) tick();
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL wait_state: valid=%b req=%b expected 0/1", instr_valid, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0021;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    tests++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || OpCode !== 6'h00 || funct !== 6'h21) begin
      fails++;
      $display("FAIL latency: valid=%b req=%b op=%h fn=%h expected 1/0/00/21", instr_valid, imem_req, OpCode, funct);
    end
    tests++;
    if (pc !== 32'h0000_3000 || pc_plus4 !== 32'h0000_3004) begin
      fails++;
      $display("FAIL latency_pc: pc=%h pc_plus4=%h expected 00003000/00003004", pc, pc_plus4);
    end
  endtask

  task automatic test_jump();
    retire(1'b0, 1'b0, 1'b0);
    tests++;
    if (imem_addr !== 32'h0000_3004 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL seq_next: addr=%h req=%b valid=%b expected 00003004/1/0", imem_addr, imem_req, instr_valid);
    end
    fetch(32'h0800_0C10, 0);
    tests++;
    if (OpCode !== 6'h02) begin
      fails++;
      $display("FAIL jump_opcode: OpCode=%h expected 02", OpCode);
    end
    // branch also taken here: jump must still win
    retire(1'b1, 1'b1, 1'b1);
    tests++;
    if (imem_addr !== 32'h0000_3040) begin
      fails++;
      $display("FAIL jump_target: addr=%h expected 00003040", imem_addr);
    end
  endtask

  task automatic test_branch();
    fetch(32'h0800_0C02, 1);
    retire(1'b1, 1'b0, 1'b0);
    tests++;
    if (imem_addr !== 32'h0000_3008) begin
      fails++;
      $display("FAIL jump_back: addr=%h expected 00003008", imem_addr);
    end
    fetch(32'h1000_FFFF, 0);
    tests++;
    if (OpCode !== 6'h04 || funct !== 6'h3F || pc_plus4 !== 32'h0000_300C) begin
      fails++;
      $display("FAIL beq_fields: op=%h fn=%h pc_plus4=%h expected 04/3f/0000300c", OpCode, funct, pc_plus4);
    end
    retire(1'b0, 1'b1, 1'b1);
    tests++;
    if (imem_addr !== 32'h0000_3008) begin
      fails++;
      $display("FAIL branch_taken: addr=%h expected 00003008", imem_addr);
    end
    fetch(32'h1000_FFFF, 0);
    retire(1'b0, 1'b1, 1'b0);
    tests++;
    if (imem_addr !== 32'h0000_300C) begin
      fails++;
      $display("FAIL branch_not_taken: addr=%h expected 0000300c", imem_addr);
    end
  endtask

  task automatic test_hold_stable();
    fetch(32'hDEAD_BEEF, 0);
    for (int i = 0; i < 5; i++) begin
      imem_ack   = i[0];
      imem_rdata = 32'h1111_1111 * (i + 1);
      jump = 1'b1; Branch = 1'b1; zero = 1'b1;
      tick();
      tests++;
      if (instr !== 32'hDEAD_BEEF || pc !== 32'h0000_300C || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable[%0d]: instr=%h pc=%h valid=%b req=%b expected deadbeef/0000300c/1/0",
                 i, instr, pc, instr_valid, imem_req);
      end
    end
    imem_ack = 1'b0; imem_rdata = '0;
    jump = 1'b0; Branch = 1'b0; zero = 1'b0;
    retire(1'b0, 1'b0, 1'b0);
    tests++;
    if (imem_addr !== 32'h0000_3010) begin
      fails++;
      $display("FAIL hold_retire: addr=%h expected 00003010", imem_addr);
    end
  endtask

  task automatic test_wrap();
    fetch(32'h0800_0000, 0);
    retire(1'b1, 1'b0, 1'b0);
    tests++;
    if (imem_addr !== 32'h0000_0000) begin
      fails++;
      $display("FAIL jump_zero: addr=%h expected 00000000", imem_addr);
    end
    fetch(32'h1000_FFFE, 0);
    retire(1'b0, 1'b1, 1'b1);
    tests++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL branch_wrap: addr=%h expected fffffffc", imem_addr);
    end
    fetch(32'h0000_0020, 0);
    tests++;
    if (pc_plus4 !== 32'h0000_0000 || fault !== 1'b0) begin
      fails++;
      $display("FAIL pc_plus4_wrap: pc_plus4=%h fault=%b expected 00000000/0", pc_plus4, fault);
    end
    retire(1'b0, 1'b0, 1'b0);
    tests++;
    if (imem_addr !== 32'h0000_0000 || fault !== 1'b0 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL seq_wrap: addr=%h fault=%b req=%b expected 00000000/0/1", imem_addr, fault, imem_req);
    end
  endtask

  task automatic test_timeout();
    // retire/jump inputs are driven during FETCH and must have no effect
    instr_ready = 1'b1; jump = 1'b1;
    repeat (15) tick();
    tests++;
    if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      fails++;
      $display("FAIL pre_timeout: fault=%b req=%b addr=%h expected 0/1/00000000", fault, imem_req, imem_addr);
    end
    tick();
    instr_ready = 1'b0; jump = 1'b0;
    tests++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout: fault=%b req=%b valid=%b expected 1/0/0", fault, imem_req, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    repeat (3) tick();
    imem_ack = 1'b0; imem_rdata = '0;
    tests++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h0000_0020 || pc !== 32'h0) begin
      fails++;
      $display("FAIL halt_frozen: fault=%b req=%b instr=%h pc=%h expected 1/0/00000020/00000000",
               fault, imem_req, instr, pc);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (fault !== 1'b0 || pc !== 32'h0000_3000 || instr !== 32'h0) begin
      fails++;
      $display("FAIL halt_reset: fault=%b pc=%h instr=%h expected 0/00003000/0", fault, pc, instr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      fails++;
      $display("FAIL restart: req=%b addr=%h expected 1/00003000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_on_ack();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; rst_n = 1'b0;
    #1;
    tests++;
    if (instr !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_ack_async: instr=%h req=%b valid=%b expected 0/0/0", instr, imem_req, instr_valid);
    end
    tick();
    tests++;
    if (instr !== 32'h0) begin
      fails++;
      $display("FAIL rst_ack_edge: instr=%h expected 0", instr);
    end
    rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    tick();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || instr !== 32'h0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_ack_restart: req=%b addr=%h instr=%h valid=%b expected 1/00003000/0/0",
               imem_req, imem_addr, instr, instr_valid);
    end
    fetch(32'h0000_0021, 0);
    tests++;
    if (pc !== 32'h0000_3000) begin
      fails++;
      $display("FAIL rst_ack_fetch: pc=%h expected 00003000", pc);
    end
  endtask

  task automatic test_misaligned();
    rst2_n = 1'b1;
    tick();
    tests++;
    if (req2 !== 1'b1 || addr2 !== 32'h0000_3002) begin
      fails++;
      $display("FAIL mis_req: req=%b addr=%h expected 1/00003002", req2, addr2);
    end
    ack2 = 1'b1; rdata2 = 32'h0000_0021;
    tick();
    ack2 = 1'b0; rdata2 = '0;
    tests++;
    if (valid2 !== 1'b1 || pcp4_2 !== 32'h0000_3006) begin
      fails++;
      $display("FAIL mis_hold: valid=%b pc_plus4=%h expected 1/00003006", valid2, pcp4_2);
    end
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    tests++;
    if (fault2 !== 1'b1 || pc2 !== 32'h0000_3002 || req2 !== 1'b0 || valid2 !== 1'b0) begin
      fails++;
      $display("FAIL mis_fault: fault=%b pc=%h req=%b valid=%b expected 1/00003002/0/0",
               fault2, pc2, req2, valid2);
    end
    repeat (2) tick();
    tests++;
    if (fault2 !== 1'b1 || req2 !== 1'b0 || pc2 !== 32'h0000_3002) begin
      fails++;
      $display("FAIL mis_halt: fault=%b req=%b pc=%h expected 1/0/00003002", fault2, req2, pc2);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_jump();
    test_branch();
    test_hold_stable();
    test_wrap();
    test_timeout();
    test_reset_on_ack();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
